// File: rtl/uart_fifo_bridge_pkg.sv
// Shared types and constants for the UART host-side FIFO bridge.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// CPU register port plus UART parallel-side signals of the FIFO bridge.
interface uart_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                            wr_en;
    logic [uart_pkg::UART_DATA_W-1:0] wr_data;
    logic                            rd_en;
    logic [uart_pkg::UART_DATA_W-1:0] rd_data;
    logic                            tx_full;
    logic                            tx_empty;
    logic                            rx_full;
    logic                            rx_empty;
    logic [DEPTH_LOG2:0]             tx_level;
    logic [DEPTH_LOG2:0]             rx_level;
    logic                            rx_overrun;
    logic                            rx_frame_err;
    logic                            clr_err;
    logic                            uart_transmit;
    logic [uart_pkg::UART_DATA_W-1:0] uart_tx_byte;
    logic                            uart_is_transmitting;
    logic                            uart_received;
    logic [uart_pkg::UART_DATA_W-1:0] uart_rx_byte;
    logic                            uart_recv_error;
    logic                            uart_recv_ack;

    // master: the host CPU and the UART core around the bridge
    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        output uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
        input  rd_data, tx_full, tx_empty, rx_full, rx_empty, tx_level, rx_level,
        input  rx_overrun, rx_frame_err, uart_transmit, uart_tx_byte, uart_recv_ack
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        input  uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
        output rd_data, tx_full, tx_empty, rx_full, rx_empty, tx_level, rx_level,
        output rx_overrun, rx_frame_err, uart_transmit, uart_tx_byte, uart_recv_ack
    );
endinterface

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO; status derived from a level counter.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic                pop,
    input  logic [W-1:0]        din,
    output logic [W-1:0]        dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  do_push, do_pop;

    assign full    = (cnt == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the counter.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-side TX/RX byte buffering between a CPU register port and a UART core.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input logic               clk,
    input logic               rstn,
    uart_fifo_bridge_if.slave bus
);
    logic [UART_DATA_W-1:0] tx_head;
    logic                   tx_pop, tx_empty, rx_full;
    logic                   rx_event, rx_push;

    tx_state_t              state_q, state_d;
    logic                   transmit_q, transmit_d;
    logic [UART_DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic                   ack_q, overrun_q, frame_err_q;

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(UART_DATA_W)) u_tx_fifo (
        .clk(clk), .rstn(rstn),
        .push(bus.wr_en), .pop(tx_pop), .din(bus.wr_data), .dout(tx_head),
        .full(bus.tx_full), .empty(tx_empty), .level(bus.tx_level)
    );

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(UART_DATA_W)) u_rx_fifo (
        .clk(clk), .rstn(rstn),
        .push(rx_push), .pop(bus.rd_en), .din(bus.uart_rx_byte), .dout(bus.rd_data),
        .full(rx_full), .empty(bus.rx_empty), .level(bus.rx_level)
    );

    assign bus.tx_empty      = tx_empty;
    assign bus.rx_full       = rx_full;
    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = tx_byte_q;
    assign bus.uart_recv_ack = ack_q;
    assign bus.rx_overrun    = overrun_q;
    assign bus.rx_frame_err  = frame_err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= TX_IDLE;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        transmit_d = transmit_q;
        tx_byte_d  = tx_byte_q;
        tx_pop     = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !bus.uart_is_transmitting) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_head;
                    transmit_d = 1'b1;
                    state_d    = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                if (bus.uart_is_transmitting) begin
                    transmit_d = 1'b0;
                    state_d    = TX_WAIT_DONE;
                end
            end
            // Falling busy also covers the UART's stop-bit time.
            TX_WAIT_DONE: begin
                if (!bus.uart_is_transmitting) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // The UART flags stay high through the ack cycle, so mask them there.
    assign rx_event = (bus.uart_received | bus.uart_recv_error) & ~ack_q;
    assign rx_push  = rx_event & bus.uart_received;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ack_q <= rx_event;
            if (rx_push && rx_full)                    overrun_q   <= 1'b1;
            else if (bus.clr_err)                      overrun_q   <= 1'b0;
            if (rx_event && bus.uart_recv_error)       frame_err_q <= 1'b1;
            else if (bus.clr_err)                      frame_err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: queue-based reference model, random and directed traffic.
module tb_uart_fifo_bridge;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_bridge_if #(.DEPTH_LOG2(DL)) bif ();

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rstn(rstn), .bus(bif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] txq[$];   // bytes written but not yet launched
    logic [7:0] rxq[$];   // bytes held in the RX FIFO
    logic ack_m = 1'b0, ovr_m = 1'b0, ferr_m = 1'b0;
    logic busy_at_edge = 1'b0, rst_at_edge = 1'b0, started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the rules on the values present at each rising edge.
    initial begin
        logic ev, full_pre, ovr_set, ferr_set;
        forever begin
            @(posedge clk);
            started      = 1'b1;
            busy_at_edge = bif.uart_is_transmitting;
            rst_at_edge  = !rstn;
            if (!rstn) begin
                txq.delete();
                rxq.delete();
                ack_m = 1'b0; ovr_m = 1'b0; ferr_m = 1'b0;
            end else begin
                if (bif.wr_en && txq.size() < DEPTH) txq.push_back(bif.wr_data);
                ev       = (bif.uart_received || bif.uart_recv_error) && !ack_m;
                full_pre = (rxq.size() == DEPTH);
                ovr_set  = 1'b0;
                ferr_set = ev && bif.uart_recv_error;
                if (bif.rd_en && rxq.size() > 0) rxq.delete(0);
                if (ev && bif.uart_received) begin
                    if (!full_pre) rxq.push_back(bif.uart_rx_byte);
                    else           ovr_set = 1'b1;
                end
                ovr_m  = ovr_set  ? 1'b1 : (bif.clr_err ? 1'b0 : ovr_m);
                ferr_m = ferr_set ? 1'b1 : (bif.clr_err ? 1'b0 : ferr_m);
                ack_m  = ev;
            end
        end
    end

    // Monitor: consumes launches from the TX scoreboard and checks every status output.
    initial begin
        logic       prev_tx   = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (started) begin
                if (rst_at_edge) begin
                    chk("rst_transmit", bif.uart_transmit, 0);
                    chk("rst_tx_byte", bif.uart_tx_byte, 0);
                end
                if (bif.uart_transmit && !prev_tx) begin
                    chk("launch_while_busy", busy_at_edge, 0);
                    if (txq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_spurious_launch: byte %0h with nothing queued at %0t",
                                 bif.uart_tx_byte, $time);
                    end else begin
                        chk("tx_byte", bif.uart_tx_byte, txq[0]);
                        txq.delete(0);
                    end
                end
                if (bif.uart_transmit && prev_tx) chk("tx_byte_hold", bif.uart_tx_byte, prev_byte);
                prev_tx   = bif.uart_transmit;
                prev_byte = bif.uart_tx_byte;
                chk("tx_level", bif.tx_level, txq.size());
                chk("tx_empty", bif.tx_empty, txq.size() == 0);
                chk("tx_full", bif.tx_full, txq.size() == DEPTH);
                chk("rx_level", bif.rx_level, rxq.size());
                chk("rx_empty", bif.rx_empty, rxq.size() == 0);
                chk("rx_full", bif.rx_full, rxq.size() == DEPTH);
                chk("rd_data", bif.rd_data, rxq.size() > 0 ? rxq[0] : 8'h00);
                chk("recv_ack", bif.uart_recv_ack, ack_m);
                chk("rx_overrun", bif.rx_overrun, ovr_m);
                chk("rx_frame_err", bif.rx_frame_err, ferr_m);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // UART transmitter: answers each launch with a busy window of random length.
    task automatic tx_responder(input int n);
        int dly  = 0;
        int hold = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
                if (hold == 0) bif.uart_is_transmitting = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    bif.uart_is_transmitting = 1'b1;
                    hold = $urandom_range(2, 6);
                end
            end else if (bif.uart_transmit && !bif.uart_is_transmitting) begin
                dly = $urandom_range(1, 3);
            end
        end
        bif.uart_is_transmitting = 1'b0;
    endtask

    // UART receiver: raises received/error, drops on ack or occasionally holds for a new byte.
    task automatic rx_driver(input int n);
        logic active = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!active) begin
                if ($urandom_range(0, 3) == 0) begin
                    bif.uart_received   = ($urandom_range(0, 9) != 0);
                    bif.uart_recv_error = ($urandom_range(0, 9) == 0);
                    if (!bif.uart_received && !bif.uart_recv_error) bif.uart_received = 1'b1;
                    bif.uart_rx_byte = 8'($urandom);
                    active = 1'b1;
                end
            end else if (bif.uart_recv_ack) begin
                if ($urandom_range(0, 7) == 0) bif.uart_rx_byte = 8'($urandom);
                else begin
                    bif.uart_received   = 1'b0;
                    bif.uart_recv_error = 1'b0;
                    active = 1'b0;
                end
            end
        end
        bif.uart_received   = 1'b0;
        bif.uart_recv_error = 1'b0;
    endtask

    task automatic cpu_random(input int n, input int rd_pct);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bif.wr_en   = ($urandom_range(0, 2) == 0);
            bif.wr_data = 8'($urandom);
            bif.rd_en   = ($urandom_range(0, 99) < rd_pct);
            bif.clr_err = ($urandom_range(0, 19) == 0);
        end
        bif.wr_en   = 1'b0;
        bif.rd_en   = 1'b0;
        bif.clr_err = 1'b0;
    endtask

    initial begin
        bif.wr_en = 0; bif.wr_data = 0; bif.rd_en = 0; bif.clr_err = 0;
        bif.uart_is_transmitting = 0; bif.uart_received = 0;
        bif.uart_rx_byte = 0; bif.uart_recv_error = 0;
        nclk(3);
        rstn = 1'b1;
        nclk(2);

        // Single byte TX with the UART idle
        bif.wr_en = 1; bif.wr_data = 8'hA5;
        nclk(1); bif.wr_en = 0;
        nclk(1);
        chk("single_launch", bif.uart_transmit, 1);
        chk("single_byte", bif.uart_tx_byte, 8'hA5);
        nclk(1);
        chk("single_hold", bif.uart_transmit, 1);
        bif.uart_is_transmitting = 1;
        nclk(1);
        chk("single_drop", bif.uart_transmit, 0);
        chk("single_tx_empty", bif.tx_empty, 1);
        nclk(2); bif.uart_is_transmitting = 0; nclk(2);

        // Back-to-back writes while the UART is busy, then drain
        bif.uart_is_transmitting = 1;
        nclk(1); bif.wr_en = 1; bif.wr_data = 8'h01;
        nclk(1); bif.wr_data = 8'h02; chk("b2b_level1", bif.tx_level, 1);
        nclk(1); bif.wr_data = 8'h03; chk("b2b_level2", bif.tx_level, 2);
        nclk(1); bif.wr_en = 0;       chk("b2b_level3", bif.tx_level, 3);
        bif.uart_is_transmitting = 0;
        tx_responder(100);
        chk("b2b_drained", bif.tx_empty, 1);

        // RX with the received flag held through the ack cycle
        bif.uart_received = 1; bif.uart_rx_byte = 8'h3C;
        nclk(1);
        chk("rxhold_ack", bif.uart_recv_ack, 1);
        chk("rxhold_data", bif.rd_data, 8'h3C);
        nclk(1);
        chk("rxhold_ack_low", bif.uart_recv_ack, 0);
        chk("rxhold_level", bif.rx_level, 1);
        bif.uart_received = 0; bif.rd_en = 1;
        nclk(1); bif.rd_en = 0;
        chk("rxhold_popped", bif.rx_empty, 1);

        // Overrun: 16 bytes fill the FIFO, the 17th (0x77) is dropped
        for (int i = 0; i < DEPTH + 1; i++) begin
            bif.uart_received = 1;
            bif.uart_rx_byte  = (i == DEPTH) ? 8'h77 : 8'(8'h10 + i);
            nclk(1); bif.uart_received = 0;
            nclk(1);
        end
        chk("ovr_flag", bif.rx_overrun, 1);
        chk("ovr_level", bif.rx_level, DEPTH);
        chk("ovr_head", bif.rd_data, 8'h10);
        bif.clr_err = 1; nclk(1); bif.clr_err = 0;
        chk("ovr_cleared", bif.rx_overrun, 0);

        // Frame error with a simultaneous push and pop
        bif.rd_en = 1; nclk(1);
        bif.uart_received = 1; bif.uart_recv_error = 1; bif.uart_rx_byte = 8'h5A;
        nclk(1);
        chk("ferr_flag", bif.rx_frame_err, 1);
        chk("ferr_ack", bif.uart_recv_ack, 1);
        chk("ferr_level", bif.rx_level, DEPTH - 1);
        bif.uart_received = 0; bif.uart_recv_error = 0; bif.rd_en = 0;
        nclk(1);
        chk("ferr_ack_once", bif.uart_recv_ack, 0);
        bif.rd_en = 1; nclk(DEPTH); bif.rd_en = 0;
        chk("ferr_drained", bif.rx_empty, 1);
        bif.clr_err = 1; nclk(1); bif.clr_err = 0;
        chk("ferr_cleared", bif.rx_frame_err, 0);

        // Reset during TX_WAIT_DONE with 5 bytes still queued
        bif.uart_is_transmitting = 1;
        for (int i = 0; i < 6; i++) begin
            bif.wr_en = 1; bif.wr_data = 8'(8'hC0 + i); nclk(1);
        end
        bif.wr_en = 0;
        bif.uart_is_transmitting = 0;
        nclk(1);
        chk("rst_pre_launch", bif.uart_transmit, 1);
        bif.uart_is_transmitting = 1;
        nclk(1);
        chk("rst_pre_level", bif.tx_level, 5);
        rstn = 0; nclk(2); rstn = 1;
        chk("rst_tx_level", bif.tx_level, 0);
        chk("rst_tx_empty", bif.tx_empty, 1);
        bif.wr_en = 1; bif.wr_data = 8'h99; nclk(1); bif.wr_en = 0;
        nclk(3);
        chk("rst_no_launch_busy", bif.uart_transmit, 0);
        bif.uart_is_transmitting = 0;
        nclk(2);
        chk("rst_launch_after_idle", bif.uart_transmit, 1);
        chk("rst_launch_byte", bif.uart_tx_byte, 8'h99);
        bif.uart_is_transmitting = 1; nclk(3);
        bif.uart_is_transmitting = 0; nclk(2);

        // Randomised traffic: RX-heavy backlog first, then fast draining
        fork
            tx_responder(1900);
            rx_driver(1500);
            begin
                cpu_random(750, 10);
                cpu_random(750, 60);
            end
        join
        bif.rd_en = 1; nclk(DEPTH + 4); bif.rd_en = 0;
        nclk(2);
        chk("final_tx_empty", bif.tx_empty, 1);
        chk("final_rx_empty", bif.rx_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
